// File: rtl/fft4_pkg.sv
// Shared definitions for the 4-point FFT datapath: sizes, complex sample type
// and the 2-bit bit-reversal used for DIT input ordering.
package fft4_pkg;

  localparam int unsigned DATA_W_DEFAULT = 16;
  localparam int unsigned FFT_N          = 4;
  localparam int unsigned IDX_W          = 2;
  localparam int unsigned CNT_W          = 16;

  typedef struct packed {
    logic [DATA_W_DEFAULT-1:0] re;
    logic [DATA_W_DEFAULT-1:0] im;
  } cplx_t;

  function automatic logic [IDX_W-1:0] bitrev2(input logic [IDX_W-1:0] k);
    return {k[0], k[1]};
  endfunction

endpackage

// File: rtl/fft4_frame_bank.sv
// Four-slot complex register file: single indexed write port, all slots
// read out in parallel.
module fft4_frame_bank
  import fft4_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           we_i,
  input  logic [IDX_W-1:0]               idx_i,
  input  logic [DATA_W-1:0]              wr_re_i,
  input  logic [DATA_W-1:0]              wr_im_i,
  output logic [FFT_N-1:0][DATA_W-1:0]   rd_re_o,
  output logic [FFT_N-1:0][DATA_W-1:0]   rd_im_o
);

  logic [FFT_N-1:0][DATA_W-1:0] re_q;
  logic [FFT_N-1:0][DATA_W-1:0] im_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      re_q <= '0;
      im_q <= '0;
    end else if (we_i) begin
      re_q[idx_i] <= wr_re_i;
      im_q[idx_i] <= wr_im_i;
    end
  end

  assign rd_re_o = re_q;
  assign rd_im_o = im_q;

endmodule

// File: rtl/fft4_in_loader.sv
// Streaming front end for fft4: packs four samples per frame into ping-pong
// banks and hands complete frames to the core over a frame-level handshake.
module fft4_in_loader
  import fft4_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned BITREV = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_re,
  input  logic [DATA_W-1:0] s_im,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] x0_re,
  output logic [DATA_W-1:0] x0_im,
  output logic [DATA_W-1:0] x1_re,
  output logic [DATA_W-1:0] x1_im,
  output logic [DATA_W-1:0] x2_re,
  output logic [DATA_W-1:0] x2_im,
  output logic [DATA_W-1:0] x3_re,
  output logic [DATA_W-1:0] x3_im,
  input  logic              err_clr,
  output logic              sync_err,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(FFT_N - 1);

  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [1:0]       full_q, full_d;
  logic             sync_err_q, sync_err_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;

  logic [FFT_N-1:0][DATA_W-1:0] x_re_q, x_re_d;
  logic [FFT_N-1:0][DATA_W-1:0] x_im_q, x_im_d;

  logic             accept_c;
  logic             handoff_c;
  logic [1:0]       bank_we_c;
  logic [IDX_W-1:0] wr_slot_c;

  logic [FFT_N-1:0][DATA_W-1:0] b0_re, b0_im, b1_re, b1_im;
  logic [FFT_N-1:0][DATA_W-1:0] b0_re_n, b0_im_n, b1_re_n, b1_im_n;

  assign accept_c  = s_valid && s_ready_q;
  assign handoff_c = m_valid_q && m_ready;
  assign wr_slot_c = (BITREV != 0) ? bitrev2(wr_cnt_q) : wr_cnt_q;

  fft4_frame_bank #(.DATA_W(DATA_W)) u_bank0 (
    .clk     (clk),
    .reset   (reset),
    .we_i    (bank_we_c[0]),
    .idx_i   (wr_slot_c),
    .wr_re_i (s_re),
    .wr_im_i (s_im),
    .rd_re_o (b0_re),
    .rd_im_o (b0_im)
  );

  fft4_frame_bank #(.DATA_W(DATA_W)) u_bank1 (
    .clk     (clk),
    .reset   (reset),
    .we_i    (bank_we_c[1]),
    .idx_i   (wr_slot_c),
    .wr_re_i (s_re),
    .wr_im_i (s_im),
    .rd_re_o (b1_re),
    .rd_im_o (b1_im)
  );

  // Write side, s_last alignment check and read-side hand-off bookkeeping.
  always_comb begin
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    full_d      = full_q;
    sync_err_d  = sync_err_q;
    frame_cnt_d = frame_cnt_q;
    bank_we_c   = 2'b00;

    if (err_clr) begin
      sync_err_d = 1'b0;
    end

    if (accept_c) begin
      if (s_last && (wr_cnt_q != LAST_SLOT)) begin
        // Early s_last: drop this beat and the partial frame.
        sync_err_d = 1'b1;
        wr_cnt_d   = '0;
      end else begin
        bank_we_c[wr_bank_q] = 1'b1;
        if (wr_cnt_q == LAST_SLOT) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
          wr_cnt_d          = '0;
          if (!s_last) begin
            sync_err_d = 1'b1;
          end
        end else begin
          wr_cnt_d = wr_cnt_q + IDX_W'(1);
        end
      end
    end

    if (handoff_c) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      frame_cnt_d       = frame_cnt_q + CNT_W'(1);
    end

    s_ready_d = !full_d[wr_bank_d];
    m_valid_d = full_d[rd_bank_d];
  end

  // Post-edge bank contents, so the x buses can be registered copies of rd_bank.
  always_comb begin
    b0_re_n = b0_re;
    b0_im_n = b0_im;
    b1_re_n = b1_re;
    b1_im_n = b1_im;
    if (bank_we_c[0]) begin
      b0_re_n[wr_slot_c] = s_re;
      b0_im_n[wr_slot_c] = s_im;
    end
    if (bank_we_c[1]) begin
      b1_re_n[wr_slot_c] = s_re;
      b1_im_n[wr_slot_c] = s_im;
    end
    x_re_d = rd_bank_d ? b1_re_n : b0_re_n;
    x_im_d = rd_bank_d ? b1_im_n : b0_im_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      full_q      <= 2'b00;
      sync_err_q  <= 1'b0;
      frame_cnt_q <= '0;
      s_ready_q   <= 1'b1;
      m_valid_q   <= 1'b0;
      x_re_q      <= '0;
      x_im_q      <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      full_q      <= full_d;
      sync_err_q  <= sync_err_d;
      frame_cnt_q <= frame_cnt_d;
      s_ready_q   <= s_ready_d;
      m_valid_q   <= m_valid_d;
      x_re_q      <= x_re_d;
      x_im_q      <= x_im_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign sync_err  = sync_err_q;
  assign frame_cnt = frame_cnt_q;
  assign x0_re     = x_re_q[0];
  assign x1_re     = x_re_q[1];
  assign x2_re     = x_re_q[2];
  assign x3_re     = x_re_q[3];
  assign x0_im     = x_im_q[0];
  assign x1_im     = x_im_q[1];
  assign x2_im     = x_im_q[2];
  assign x3_im     = x_im_q[3];

endmodule

// File: tb/tb_fft4_in_loader.sv
// Directed bench for fft4_in_loader: natural-order and bit-reversed instances
// share one input stream; expected values are hand-computed constants.
module tb_fft4_in_loader;

  logic        clk;
  logic        reset;
  logic        s_valid;
  logic [15:0] s_re;
  logic [15:0] s_im;
  logic        s_last;
  logic        m_ready;
  logic        err_clr;

  logic        s_ready, m_valid, sync_err;
  logic [15:0] frame_cnt;
  logic [15:0] x0_re, x0_im, x1_re, x1_im, x2_re, x2_im, x3_re, x3_im;

  logic        br_s_ready, br_m_valid, br_sync_err;
  logic [15:0] br_frame_cnt;
  logic [15:0] br_x0_re, br_x0_im, br_x1_re, br_x1_im, br_x2_re, br_x2_im, br_x3_re, br_x3_im;

  int errors;
  int checks;
  int stalls;

  fft4_in_loader #(.DATA_W(16), .BITREV(0)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_re(s_re), .s_im(s_im), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
    .x2_re(x2_re), .x2_im(x2_im), .x3_re(x3_re), .x3_im(x3_im),
    .err_clr(err_clr), .sync_err(sync_err), .frame_cnt(frame_cnt)
  );

  fft4_in_loader #(.DATA_W(16), .BITREV(1)) dut_br (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(br_s_ready),
    .s_re(s_re), .s_im(s_im), .s_last(s_last), .m_valid(br_m_valid), .m_ready(m_ready),
    .x0_re(br_x0_re), .x0_im(br_x0_im), .x1_re(br_x1_re), .x1_im(br_x1_im),
    .x2_re(br_x2_re), .x2_im(br_x2_im), .x3_re(br_x3_re), .x3_im(br_x3_im),
    .err_clr(err_clr), .sync_err(br_sync_err), .frame_cnt(br_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until the edge that accepts it.
  task automatic send(input logic [15:0] re, input logic [15:0] im, input logic last);
    int n;
    s_valid = 1'b1;
    s_re    = re;
    s_im    = im;
    s_last  = last;
    n = 0;
    while (!s_ready && n < 20) begin
      tick();
      n++;
      stalls++;
    end
    if (n >= 20) check("send_timeout", 16'(s_ready), 16'd1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    stalls  = 0;
    reset   = 1'b1;
    s_valid = 1'b0;
    s_re    = '0;
    s_im    = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_s_ready", 16'(s_ready), 16'd1);
    check("rst_m_valid", 16'(m_valid), 16'd0);
    check("rst_sync_err", 16'(sync_err), 16'd0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_x_or", x0_re | x1_re | x2_re | x3_re | x0_im | x3_im, 16'd0);

    // Basic frame, natural and bit-reversed placement
    m_ready = 1'b1;
    send(16'd1, 16'd0, 1'b0);
    send(16'd2, 16'd0, 1'b0);
    send(16'd3, 16'd0, 1'b0);
    send(16'd4, 16'd0, 1'b1);
    check("f1_m_valid", 16'(m_valid), 16'd1);
    check("f1_x0", x0_re, 16'd1);
    check("f1_x1", x1_re, 16'd2);
    check("f1_x2", x2_re, 16'd3);
    check("f1_x3", x3_re, 16'd4);
    check("br_m_valid", 16'(br_m_valid), 16'd1);
    check("br_x0", br_x0_re, 16'd1);
    check("br_x1", br_x1_re, 16'd3);
    check("br_x2", br_x2_re, 16'd2);
    check("br_x3", br_x3_re, 16'd4);
    check("br_im", br_x0_im | br_x1_im | br_x2_im | br_x3_im, 16'd0);
    tick();
    check("f1_m_valid_pulse", 16'(m_valid), 16'd0);
    check("f1_frame_cnt", frame_cnt, 16'd1);
    check("br_frame_cnt", br_frame_cnt, 16'd1);
    check("br_s_ready", 16'(br_s_ready), 16'd1);

    // Back-pressure: both banks fill, then frames leave in order
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(16'(16'h10 + i), 16'd0, (i % 4) == 3);
    check("bp_s_ready_full", 16'(s_ready), 16'd0);
    check("bp_m_valid", 16'(m_valid), 16'd1);
    check("bp_A_x0", x0_re, 16'h10);
    check("bp_A_x3", x3_re, 16'h13);
    s_valid = 1'b1;
    s_re    = 16'h18;
    s_im    = 16'd0;
    s_last  = 1'b0;
    tick();
    tick();
    check("bp_s_ready_hold", 16'(s_ready), 16'd0);
    check("bp_A_stable", x1_re, 16'h11);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("bp_cnt_after_A", frame_cnt, 16'd2);
    check("bp_s_ready_free", 16'(s_ready), 16'd1);
    check("bp_B_x0", x0_re, 16'h14);
    check("bp_B_x3", x3_re, 16'h17);
    for (int i = 8; i < 12; i++) send(16'(16'h10 + i), 16'd0, (i % 4) == 3);
    check("bp_s_ready_full2", 16'(s_ready), 16'd0);
    check("bp_B_hold", x2_re, 16'h16);
    m_ready = 1'b1;
    tick();
    check("bp_cnt_after_B", frame_cnt, 16'd3);
    check("bp_C_x0", x0_re, 16'h18);
    check("bp_C_x3", x3_re, 16'h1B);
    tick();
    check("bp_cnt_after_C", frame_cnt, 16'd4);
    check("bp_drained", 16'(m_valid), 16'd0);

    // Early s_last discards the partial frame; clean frame passes bit-exact
    send(16'h7FFF, 16'd0, 1'b0);
    send(16'h8000, 16'd0, 1'b1);
    check("se_sync_err", 16'(sync_err), 16'd1);
    check("se_no_frame", 16'(m_valid), 16'd0);
    send(16'h1234, 16'h5555, 1'b0);
    send(16'h9ABC, 16'hFFFF, 1'b0);
    send(16'h0F0F, 16'h8001, 1'b0);
    send(16'hAAAA, 16'h0001, 1'b1);
    check("se_m_valid", 16'(m_valid), 16'd1);
    check("se_x0_re", x0_re, 16'h1234);
    check("se_x1_re", x1_re, 16'h9ABC);
    check("se_x2_re", x2_re, 16'h0F0F);
    check("se_x3_re", x3_re, 16'hAAAA);
    check("se_x0_im", x0_im, 16'h5555);
    check("se_x1_im", x1_im, 16'hFFFF);
    check("se_x2_im", x2_im, 16'h8001);
    check("se_x3_im", x3_im, 16'h0001);
    check("se_br_x1_re", br_x1_re, 16'h0F0F);
    check("se_br_x2_im", br_x2_im, 16'hFFFF);
    check("se_br_sync_err", 16'(br_sync_err), 16'd1);
    tick();
    check("se_frame_cnt", frame_cnt, 16'd5);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("se_err_clr", 16'(sync_err), 16'd0);

    // Missing s_last on the 4th beat: error flagged, frame still delivered,
    // and the error wins over a simultaneous clear
    send(16'h21, 16'd0, 1'b0);
    send(16'h22, 16'd0, 1'b0);
    send(16'h23, 16'd0, 1'b0);
    err_clr = 1'b1;
    send(16'h24, 16'd0, 1'b0);
    err_clr = 1'b0;
    check("ml_sync_err", 16'(sync_err), 16'd1);
    check("ml_m_valid", 16'(m_valid), 16'd1);
    check("ml_x0", x0_re, 16'h21);
    check("ml_x3", x3_re, 16'h24);
    tick();
    check("ml_frame_cnt", frame_cnt, 16'd6);

    // Reset in the middle of a frame
    send(16'h31, 16'd0, 1'b0);
    send(16'h32, 16'd0, 1'b0);
    reset = 1'b1;
    #1;
    check("mr_frame_cnt", frame_cnt, 16'd0);
    check("mr_sync_err", 16'(sync_err), 16'd0);
    check("mr_x0", x0_re, 16'd0);
    tick();
    reset = 1'b0;
    send(16'h41, 16'd0, 1'b0);
    send(16'h42, 16'd0, 1'b0);
    send(16'h43, 16'd0, 1'b0);
    send(16'h44, 16'd0, 1'b1);
    check("mr_m_valid", 16'(m_valid), 16'd1);
    check("mr_x0", x0_re, 16'h41);
    check("mr_x1", x1_re, 16'h42);
    check("mr_x2", x2_re, 16'h43);
    check("mr_x3", x3_re, 16'h44);
    tick();
    check("mr_frame_cnt_after", frame_cnt, 16'd1);

    // Sustained stream across the frame counter wrap
    force dut.frame_cnt_q = 16'hFFFE;
    tick();
    release dut.frame_cnt_q;
    check("wr_preset", frame_cnt, 16'hFFFE);
    stalls = 0;
    for (int i = 0; i < 12; i++) send(16'(16'h50 + i), 16'd0, (i % 4) == 3);
    check("wr_no_stall", 16'(stalls), 16'd0);
    check("wr_s_ready", 16'(s_ready), 16'd1);
    check("wr_wrapped", frame_cnt, 16'h0000);
    check("wr_x0", x0_re, 16'h58);
    tick();
    check("wr_after_wrap", frame_cnt, 16'h0001);
    check("wr_sync_err", 16'(sync_err), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
